// File: rtl/fir_pkg.sv
// fir_pkg: constants and types shared by the TinyTapeout FIR filter and its
// downstream stages.
//   FIR_BW_OUT      - width of the FIR output samples
//   DEF_LOG2_DEC    - default log2 of the decimation factor
//   DEF_FIFO_DEPTH  - default depth of the decimator output FIFO
//   fir_sample_t    - signed FIR output sample
package fir_pkg;

  localparam int FIR_BW_OUT     = 8;
  localparam int DEF_LOG2_DEC   = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef logic signed [FIR_BW_OUT-1:0] fir_sample_t;

endpackage

// File: rtl/fir_decimator_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, reset  - clock, synchronous active-high reset (clears pointers and storage)
//   push, din   - write request and data; accepted when not full, or when a
//                 pop happens in the same cycle
//   pop         - read request; ignored while empty
//   head        - oldest entry, 0 while empty
//   full, empty - occupancy flags, decoded from the pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  // The extra pointer MSB separates "full" (MSBs differ) from "empty"
  // (MSBs equal) when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full FIFO still fits when the head leaves in the same
  // cycle: the write slot is the one being vacated, read before the edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// fir_decimator: averages each non-overlapping block of 2^LOG2_DEC valid FIR
// samples into one decimated sample and queues it for a valid/ready consumer.
//   clk, reset           - clock, synchronous active-high reset
//   in_valid, in_data    - signed FIR sample, counted only when in_valid=1
//   out_valid, out_data  - FIFO head (out_data is 0 while empty)
//   out_ready            - consumer takes out_data this cycle
//   overflow             - sticky, set when a result was dropped on a full FIFO
//   ovf_clear            - clears overflow (a simultaneous drop wins)
module fir_decimator
  import fir_pkg::*;
#(
  parameter int BW_DATA    = FIR_BW_OUT,
  parameter int LOG2_DEC   = DEF_LOG2_DEC,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic signed [BW_DATA-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [BW_DATA-1:0] out_data,
  output logic                      overflow,
  input  logic                      ovf_clear
);

  // Wide enough for the sum of a full block, so no intermediate overflow.
  localparam int ACC_W = BW_DATA + LOG2_DEC;

  logic signed [ACC_W-1:0]   acc;
  logic        [LOG2_DEC-1:0] cnt;
  logic signed [ACC_W-1:0]   sum;
  logic        [BW_DATA-1:0] result;
  logic                      block_end;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic                      drop;
  logic        [BW_DATA-1:0] head;

  assign sum       = acc + ACC_W'(in_data);
  assign block_end = in_valid && (cnt == '1);

  // Arithmetic shift rounds toward minus infinity; the mean of BW_DATA-bit
  // samples always fits back into BW_DATA bits, so truncation is lossless.
  assign result = BW_DATA'(sum >>> LOG2_DEC);

  assign out_valid = !fifo_empty;
  assign out_data  = head;
  assign pop       = out_valid && out_ready;
  assign drop      = block_end && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (BW_DATA),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (block_end),
    .din   (result),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The block restarts at its end even when the result is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_valid) begin
      if (block_end) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator: directed, table-driven bench for fir_decimator with
// LOG2_DEC=2 and FIFO_DEPTH=4, plus hand-written back-pressure and reset
// sequences.
module tb_fir_decimator;
  import fir_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  fir_sample_t in_data;
  logic        out_valid;
  logic        out_ready;
  fir_sample_t out_data;
  logic        overflow;
  logic        ovf_clear;

  int num_checks;
  int num_errors;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic       eo;
    string      name;
  } vec_t;

  vec_t vecs[$];

  fir_decimator #(
    .BW_DATA    (8),
    .LOG2_DEC   (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then let the edge happen and settle.
  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic rdy, input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    ovf_clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev,
                             input logic [7:0] ed, input logic eo);
    num_checks++;
    if (out_valid !== ev || out_data !== ed || overflow !== eo) begin
      num_errors++;
      $display("[TB] FAIL %s: got valid=%b data=0x%02h ovf=%b, expected valid=%b data=0x%02h ovf=%b",
               name, out_valid, out_data, overflow, ev, ed, eo);
    end
  endtask

  function automatic vec_t mk(input logic v, input int d, input logic rdy,
                              input logic clr, input logic ev, input int ed,
                              input logic eo, input string name);
    vec_t r;
    r.v = v;  r.d = 8'(d);  r.rdy = rdy;  r.clr = clr;
    r.ev = ev;  r.ed = 8'(ed);  r.eo = eo;  r.name = name;
    return r;
  endfunction

  // Feeds a block of four equal samples with the given out_ready.
  task automatic feedBlock(input int value, input logic rdy);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(value), rdy, 1'b0);
    end
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 20000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    num_checks = 0;
    num_errors = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    ovf_clear  = 1'b0;

    // Basic average 4,8,12,16 -> 10 for exactly one cycle.
    vecs.push_back(mk(1, 4,  1, 0, 0, 0,    0, "basic_s0"));
    vecs.push_back(mk(1, 8,  1, 0, 0, 0,    0, "basic_s1"));
    vecs.push_back(mk(1, 12, 1, 0, 0, 0,    0, "basic_s2"));
    vecs.push_back(mk(1, 16, 1, 0, 1, 10,   0, "basic_out"));
    vecs.push_back(mk(0, 0,  1, 0, 0, 0,    0, "basic_gone"));
    // -1,-1,-1,-2 -> sum -5 -> floor(-1.25) = -2.
    vecs.push_back(mk(1, -1, 1, 0, 0, 0,    0, "neg_s0"));
    vecs.push_back(mk(1, -1, 1, 0, 0, 0,    0, "neg_s1"));
    vecs.push_back(mk(1, -1, 1, 0, 0, 0,    0, "neg_s2"));
    vecs.push_back(mk(1, -2, 1, 0, 1, 'hFE, 0, "neg_out"));
    vecs.push_back(mk(0, 0,  1, 0, 0, 0,    0, "neg_gone"));
    // Extremes.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 127, 1, 0, 0, 0, 0, "max_s"));
    vecs.push_back(mk(1, 127, 1, 0, 1, 127, 0, "max_out"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, "max_gone"));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, -128, 1, 0, 0, 0, 0, "min_s"));
    vecs.push_back(mk(1, -128, 1, 0, 1, 'h80, 0, "min_out"));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, "min_gone"));
    // Gapped input: idle cycles never count.
    vecs.push_back(mk(1, 4,  1, 0, 0, 0, 0, "gap_s0"));
    vecs.push_back(mk(0, 99, 1, 0, 0, 0, 0, "gap_idle"));
    vecs.push_back(mk(1, 8,  1, 0, 0, 0, 0, "gap_s1"));
    vecs.push_back(mk(0, 99, 1, 0, 0, 0, 0, "gap_idle"));
    vecs.push_back(mk(0, 99, 1, 0, 0, 0, 0, "gap_idle"));
    vecs.push_back(mk(1, 12, 1, 0, 0, 0, 0, "gap_s2"));
    vecs.push_back(mk(0, 99, 1, 0, 0, 0, 0, "gap_idle"));
    vecs.push_back(mk(0, 99, 1, 0, 0, 0, 0, "gap_idle"));
    vecs.push_back(mk(0, 99, 1, 0, 0, 0, 0, "gap_idle"));
    vecs.push_back(mk(1, 16, 1, 0, 1, 10, 0, "gap_out"));
    vecs.push_back(mk(0, 0,  1, 0, 0, 0, 0, "gap_gone"));

    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("reset_state", 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    reset = 1'b0;

    $display("[TB] table vectors: %0d", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      checkOutput(vecs[i].name, vecs[i].ev, vecs[i].ed, vecs[i].eo);
    end

    // Back-pressure: five blocks averaging 1..5 with no consumer.
    $display("[TB] back-pressure overflow");
    for (int k = 1; k <= 4; k++) begin
      feedBlock(k, 1'b0);
      checkOutput($sformatf("bp_block%0d", k), 1'b1, 8'd1, 1'b0);
    end
    feedBlock(5, 1'b0);
    checkOutput("bp_block5_drop", 1'b1, 8'd1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      checkOutput($sformatf("bp_head%0d", k), 1'b1, 8'(k), 1'b1);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    end
    checkOutput("bp_drained", 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("bp_ovf_clear", 1'b0, 8'h00, 1'b0);

    // Full FIFO with a block end coinciding with a pop.
    $display("[TB] full with simultaneous push/pop");
    for (int k = 1; k <= 4; k++) begin
      feedBlock(10 * k, 1'b0);
    end
    checkOutput("full_head", 1'b1, 8'd10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'd50, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'd50, 1'b1, 1'b0);
    checkOutput("full_pushpop", 1'b1, 8'd20, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      checkOutput($sformatf("full_drain%0d", k), 1'b1, 8'(10 * k), 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    end
    checkOutput("full_empty", 1'b0, 8'h00, 1'b0);

    // Reset mid-block discards the partial sum.
    $display("[TB] reset mid-block");
    applyStimulus(1'b1, 8'd100, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd100, 1'b1, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("rst_during", 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("rst_after", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'd20, 1'b1, 1'b0);
      checkOutput("rst_partial", 1'b0, 8'h00, 1'b0);
    end
    applyStimulus(1'b1, 8'd20, 1'b1, 1'b0);
    checkOutput("rst_out", 1'b1, 8'd20, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_errors);
    $finish;
  end

endmodule
